// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the shared-bus arbiter and crossbar blocks.
//   arb_state_e : arbiter state (IDLE: bus free, GRANT: one master owns it)
//   WB_ADDR_W   : default address width
//   WB_DATA_W   : default data width
package wb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of every bus signal around the round-robin arbiter. The names are
// seen from the arbiter: _i enters the arbiter and _o leaves it.
//   m_* : N_MASTER requesting masters, packed with master 0 in the LSBs
//   s_* : the single shared slave
//   gnt : one-hot current grant (all zero when idle)
// Modports:
//   slave  : the arbiter (slave to the masters, it drives the slave bus)
//   master : the environment (requesting masters plus the slave model)
interface wb_rr_arbiter_if #(
  parameter int N_MASTER = 3,
  parameter int ADDR_W   = wb_pkg::WB_ADDR_W,
  parameter int DATA_W   = wb_pkg::WB_DATA_W
);

  logic [N_MASTER-1:0]          m_cyc_i;
  logic [N_MASTER-1:0]          m_stb_i;
  logic [N_MASTER-1:0]          m_we_i;
  logic [N_MASTER*DATA_W/8-1:0] m_sel_i;
  logic [N_MASTER*ADDR_W-1:0]   m_adr_i;
  logic [N_MASTER*DATA_W-1:0]   m_dat_i;
  logic [DATA_W-1:0]            m_dat_o;
  logic [N_MASTER-1:0]          m_ack_o;
  logic [N_MASTER-1:0]          m_err_o;

  logic                         s_cyc_o;
  logic                         s_stb_o;
  logic                         s_we_o;
  logic [DATA_W/8-1:0]          s_sel_o;
  logic [ADDR_W-1:0]            s_adr_o;
  logic [DATA_W-1:0]            s_dat_o;
  logic [DATA_W-1:0]            s_dat_i;
  logic                         s_ack_i;
  logic                         s_err_i;

  logic [N_MASTER-1:0]          gnt_o;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i, s_err_i,
    output gnt_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i, s_err_i,
    input  gnt_o
  );

endinterface

// File: rtl/wb_rr_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner selection.
//   req_i : request vector
//   ptr_i : index holding highest priority this round
//   gnt_o : one-hot winner, the first request found at or above ptr_i,
//           wrapping from N-1 back to 0; all zero when nothing is requested
module rr_picker #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  int   idx;
  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin arbiter sharing one Wishbone slave among
// N_MASTER masters. A grant lasts for as long as the owner holds CYC, so
// multi-beat and read-modify-write sequences are never interleaved.
// Ports:
//   clk    : system clock
//   rstn_i : asynchronous active-low reset
//   bus    : wb_rr_arbiter_if.slave carrying the master, slave and grant signals
// Optional build macro WB_ARB_TIMEOUT_EN adds a watchdog: after TIMEOUT
// cycles of unanswered STB the owner gets a one-cycle ERR and loses the bus.
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter int N_MASTER = 3,
  parameter int ADDR_W   = WB_ADDR_W,
  parameter int DATA_W   = WB_DATA_W,
  parameter int TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rstn_i,
  wb_rr_arbiter_if.slave   bus
);

  localparam int PW = $clog2(N_MASTER);
  localparam int SW = DATA_W / 8;

  arb_state_e          state_q, state_d;
  logic [N_MASTER-1:0] gnt_q, gnt_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [N_MASTER-1:0] pick;
  logic [PW-1:0]       gidx;
  logic                granted_cyc;
  logic                granted_stb;
  logic                timeout_hit;

  rr_picker #(.N(N_MASTER), .PW(PW)) u_picker (
    .req_i (bus.m_cyc_i),
    .ptr_i (ptr_q),
    .gnt_o (pick)
  );

  // Binary index of the current owner, used to advance the pointer.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (gnt_q[i]) gidx = PW'(i);
    end
  end

  assign granted_cyc = |(bus.m_cyc_i & gnt_q);
  assign granted_stb = |(bus.m_stb_i & gnt_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|bus.m_cyc_i) begin
          gnt_d   = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Releasing straight to IDLE guarantees one idle cycle between owners.
        if (!granted_cyc || timeout_hit) begin
          gnt_d   = '0;
          ptr_d   = (gidx == PW'(N_MASTER - 1)) ? '0 : gidx + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout_hit = (state_q == GRANT) && (cnt_q == CW'(TIMEOUT));

  // s_stb_o is forced low on the hit cycle, so the count never passes TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.s_ack_i || bus.s_err_i || (gnt_d != gnt_q)) begin
      cnt_d = '0;
    end else if ((state_q == GRANT) && bus.s_stb_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Slave-side mux; everything reads zero while no grant is held.
  always_comb begin
    bus.s_we_o  = 1'b0;
    bus.s_sel_o = '0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (gnt_q[i]) begin
        bus.s_we_o  = bus.m_we_i[i];
        bus.s_sel_o = bus.m_sel_i[i*SW +: SW];
        bus.s_adr_o = bus.m_adr_i[i*ADDR_W +: ADDR_W];
        bus.s_dat_o = bus.m_dat_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.s_cyc_o = granted_cyc & ~timeout_hit;
  assign bus.s_stb_o = granted_stb & ~timeout_hit;
  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.gnt_o   = gnt_q;

  // Responses reach only the owner; gnt_q is zero in IDLE, so stray
  // slave responses are dropped.
  generate
    for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_resp
      assign bus.m_ack_o[gi] = gnt_q[gi] & bus.s_ack_i & ~timeout_hit;
      assign bus.m_err_o[gi] = gnt_q[gi] & (bus.s_err_i | timeout_hit);
    end
  endgenerate

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter_if #(.N_MASTER(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  wb_rr_arbiter #(.N_MASTER(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.m_sel_i = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.s_dat_i = '0;
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;
  endtask

  task automatic drive_master(input int i, input logic cyc, input logic stb,
                              input logic we, input logic [AW-1:0] adr,
                              input logic [DW-1:0] dat);
    bus.m_cyc_i[i]          = cyc;
    bus.m_stb_i[i]          = stb;
    bus.m_we_i[i]           = we;
    bus.m_sel_i[i*4 +: 4]   = 4'hF;
    bus.m_adr_i[i*AW +: AW] = adr;
    bus.m_dat_i[i*DW +: DW] = dat;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_inputs();
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      if (c == 10) begin
        bus.s_ack_i = 1'b1;
        bus.s_err_i = 1'b1;
        #1;
      end
      checks++;
      if ({bus.gnt_o, bus.s_cyc_o, bus.s_stb_o, bus.m_ack_o, bus.m_err_o, bus.s_adr_o} !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: gnt=%b cyc=%b stb=%b ack=%b err=%b adr=%h, all required 0",
                 c, bus.gnt_o, bus.s_cyc_o, bus.s_stb_o, bus.m_ack_o, bus.m_err_o, bus.s_adr_o);
      end
      if (c == 10) begin
        bus.s_ack_i = 1'b0;
        bus.s_err_i = 1'b0;
      end
      step();
    end
    $display("test_reset: 20 idle cycles checked");
  endtask

  task automatic test_single();
    do_reset();
    drive_master(1, 1'b1, 1'b1, 1'b1, 32'h0000_4010, 32'hDEAD_BEEF);
    #1;
    checks++;
    if (bus.gnt_o !== 3'b000) begin
      errors++;
      $display("FAIL single_latency: gnt=%b required 000 before edge", bus.gnt_o);
    end
    step();
    checks++;
    if ({bus.gnt_o, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o} !== {3'b010, 3'b111}) begin
      errors++;
      $display("FAIL single_grant: gnt=%b cyc/stb/we=%b%b%b required 010 111",
               bus.gnt_o, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o);
    end
    checks++;
    if ({bus.s_adr_o, bus.s_dat_o, bus.s_sel_o} !== {32'h0000_4010, 32'hDEAD_BEEF, 4'hF}) begin
      errors++;
      $display("FAIL single_bus: adr=%h dat=%h sel=%h required 00004010 deadbeef f",
               bus.s_adr_o, bus.s_dat_o, bus.s_sel_o);
    end
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'h1234_5678;
    #1;
    checks++;
    if ({bus.m_ack_o, bus.m_dat_o} !== {3'b010, 32'h1234_5678}) begin
      errors++;
      $display("FAIL single_ack: ack=%b dat=%h required 010 12345678", bus.m_ack_o, bus.m_dat_o);
    end
    step();
    bus.s_ack_i = 1'b0;
    drive_master(1, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    checks++;
    if ({bus.gnt_o, bus.s_cyc_o} !== {3'b010, 1'b0}) begin
      errors++;
      $display("FAIL single_drop: gnt=%b cyc=%b required 010 0", bus.gnt_o, bus.s_cyc_o);
    end
    step();
    checks++;
    if ({bus.gnt_o, bus.s_adr_o} !== '0) begin
      errors++;
      $display("FAIL single_release: gnt=%b adr=%h required 000 0", bus.gnt_o, bus.s_adr_o);
    end
    $display("test_single: master 1 write 0x4010 done");
  endtask

  task automatic test_round_robin();
    int exp_order [6] = '{0, 1, 2, 0, 1, 2};
    logic [N-1:0] exp_gnt;
    do_reset();
    for (int i = 0; i < N; i++)
      drive_master(i, 1'b1, 1'b1, 1'b0, 32'h100 * (i + 1), '0);
    for (int g = 0; g < 6; g++) begin
      exp_gnt = N'(1) << exp_order[g];
      step();
      checks++;
      if (bus.gnt_o !== exp_gnt) begin
        errors++;
        $display("FAIL rr_grant %0d: gnt=%b required %b", g, bus.gnt_o, exp_gnt);
      end
      bus.s_ack_i = 1'b1;
      #1;
      checks++;
      if ({bus.m_ack_o, bus.s_adr_o} !== {exp_gnt, 32'h100 * (exp_order[g] + 1)}) begin
        errors++;
        $display("FAIL rr_ack %0d: ack=%b adr=%h required %b %h", g, bus.m_ack_o,
                 bus.s_adr_o, exp_gnt, 32'h100 * (exp_order[g] + 1));
      end
      step();
      bus.s_ack_i = 1'b0;
      drive_master(exp_order[g], 1'b0, 1'b0, 1'b0, '0, '0);
      step();
      checks++;
      if ({bus.gnt_o, bus.s_cyc_o} !== '0) begin
        errors++;
        $display("FAIL rr_idle_gap %0d: gnt=%b cyc=%b required 000 0", g, bus.gnt_o, bus.s_cyc_o);
      end
      drive_master(exp_order[g], 1'b1, 1'b1, 1'b0, 32'h100 * (exp_order[g] + 1), '0);
      $display("test_round_robin: grant %0d went to master %0d", g, exp_order[g]);
    end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_hold();
    do_reset();
    drive_master(2, 1'b1, 1'b1, 1'b0, 32'h0000_2000, '0);
    step();
    checks++;
    if (bus.gnt_o !== 3'b100) begin
      errors++;
      $display("FAIL hold_grant2: gnt=%b required 100", bus.gnt_o);
    end
    drive_master(0, 1'b1, 1'b1, 1'b1, 32'h0000_1000, 32'h5555_AAAA);
    for (int b = 0; b < 4; b++) begin
      bus.m_adr_i[2*AW +: AW] = 32'h2000 + 32'(4 * b);
      bus.s_dat_i = 32'hA0 + 32'(b);
      bus.s_ack_i = 1'b1;
      #1;
      checks++;
      if ({bus.m_ack_o, bus.m_dat_o, bus.s_adr_o, bus.s_we_o} !==
          {3'b100, 32'hA0 + 32'(b), 32'h2000 + 32'(4 * b), 1'b0}) begin
        errors++;
        $display("FAIL hold_beat %0d: ack=%b dat=%h adr=%h we=%b required 100 %h %h 0",
                 b, bus.m_ack_o, bus.m_dat_o, bus.s_adr_o, bus.s_we_o,
                 32'hA0 + 32'(b), 32'h2000 + 32'(4 * b));
      end
      step();
      $display("test_hold: master 2 read beat %0d", b);
    end
    bus.s_ack_i = 1'b0;
    drive_master(2, 1'b0, 1'b0, 1'b0, '0, '0);
    step();
    checks++;
    if ({bus.gnt_o, bus.s_adr_o} !== '0) begin
      errors++;
      $display("FAIL hold_gap: gnt=%b adr=%h required 000 0", bus.gnt_o, bus.s_adr_o);
    end
    step();
    checks++;
    if ({bus.gnt_o, bus.s_adr_o, bus.s_dat_o, bus.s_we_o} !== {3'b001, 32'h1000, 32'h5555_AAAA, 1'b1}) begin
      errors++;
      $display("FAIL hold_grant0: gnt=%b adr=%h dat=%h we=%b required 001 1000 5555aaaa 1",
               bus.gnt_o, bus.s_adr_o, bus.s_dat_o, bus.s_we_o);
    end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_master(1, 1'b1, 1'b1, 1'b1, 32'h0000_3000, 32'h0BAD_F00D);
    step();
    checks++;
    if (bus.gnt_o !== 3'b010) begin
      errors++;
      $display("FAIL midrst_grant: gnt=%b required 010", bus.gnt_o);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.gnt_o, bus.s_cyc_o, bus.m_err_o, bus.m_ack_o} !== '0) begin
      errors++;
      $display("FAIL midrst_async: gnt=%b cyc=%b err=%b ack=%b required all 0",
               bus.gnt_o, bus.s_cyc_o, bus.m_err_o, bus.m_ack_o);
    end
    drive_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0040, '0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    checks++;
    if ({bus.gnt_o, bus.s_adr_o} !== {3'b001, 32'h40}) begin
      errors++;
      $display("FAIL midrst_tie: gnt=%b adr=%h required 001 00000040", bus.gnt_o, bus.s_adr_o);
    end
    $display("test_reset_mid: master 0 won tie after reset");
    clear_inputs();
    step();
    step();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    drive_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_5000, '0);
    step();
    drive_master(2, 1'b1, 1'b1, 1'b0, 32'h0000_6000, '0);
    checks++;
    if (bus.gnt_o !== 3'b010) begin
      errors++;
      $display("FAIL to_grant: gnt=%b required 010", bus.gnt_o);
    end
    for (int k = 1; k < TO; k++) begin
      step();
      checks++;
      if ({bus.m_err_o, bus.s_cyc_o, bus.s_stb_o} !== {3'b000, 2'b11}) begin
        errors++;
        $display("FAIL to_wait %0d: err=%b cyc=%b stb=%b required 000 1 1",
                 k, bus.m_err_o, bus.s_cyc_o, bus.s_stb_o);
      end
    end
    step();
    checks++;
    if ({bus.m_err_o, bus.s_cyc_o, bus.s_stb_o, bus.m_ack_o} !== {3'b010, 2'b00, 3'b000}) begin
      errors++;
      $display("FAIL to_pulse: err=%b cyc=%b stb=%b ack=%b required 010 0 0 000",
               bus.m_err_o, bus.s_cyc_o, bus.s_stb_o, bus.m_ack_o);
    end
    step();
    checks++;
    if ({bus.gnt_o, bus.m_err_o} !== '0) begin
      errors++;
      $display("FAIL to_release: gnt=%b err=%b required 000 000", bus.gnt_o, bus.m_err_o);
    end
    step();
    checks++;
    if ({bus.gnt_o, bus.s_adr_o} !== {3'b100, 32'h6000}) begin
      errors++;
      $display("FAIL to_next: gnt=%b adr=%h required 100 00006000", bus.gnt_o, bus.s_adr_o);
    end
    $display("test_timeout: watchdog fired, master 2 served next");
    clear_inputs();
    step();
    step();
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_reset_mid();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone arbiter that shares one Wishbone slave port between N requesting masters (debug module, core MEM stage, core IF stage).
- Placed in front of a single slave, such as the RAM or timer, wherever the crossbar is replaced by a cheaper shared-bus arrangement.
- Grants are whole-cycle: a granted master keeps the bus for as long as it holds CYC, so multi-beat and read-modify-write sequences are never interleaved.

Parameters:
- N_MASTER, 3, number of requesting masters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; SEL width is DATA_W/8.
- TIMEOUT, 255, watchdog limit in cycles (used only with WB_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rstn_i  in  1  reset; asynchronous, active-low.
- m_cyc_i  in  N_MASTER  per-master CYC.
- m_stb_i  in  N_MASTER  per-master STB.
- m_we_i  in  N_MASTER  per-master WE.
- m_sel_i  in  N_MASTER*DATA_W/8  per-master SEL, packed with master 0 in the LSBs.
- m_adr_i  in  N_MASTER*ADDR_W  per-master address, packed.
- m_dat_i  in  N_MASTER*DATA_W  per-master write data, packed.
- m_dat_o  out  DATA_W  read data, broadcast to all masters.
- m_ack_o  out  N_MASTER  per-master ACK.
- m_err_o  out  N_MASTER  per-master ERR.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side controls.
- s_sel_o  out  DATA_W/8  slave SEL.
- s_adr_o  out  ADDR_W  slave address.
- s_dat_o  out  DATA_W  slave write data.
- s_dat_i  in  DATA_W  slave read data.
- s_ack_i, s_err_i  in  1 each  slave responses.
- gnt_o  out  N_MASTER  one-hot current grant; all-zero when the bus is idle.

Behaviour:
- Reset values: gnt_o=0, state=IDLE, priority pointer=0 (master 0 highest), s_cyc_o/s_stb_o=0. All m_ack_o/m_err_o=0. s_* data, address and SEL outputs are driven to 0 while no grant is held.
- Reset asserted mid-transaction: the grant is dropped immediately (asynchronous) and the slave sees CYC fall. There is no completion and no error for the interrupted master.
- State IDLE: when any m_cyc_i is high at a clock edge, register a one-hot grant to the first requester found at or after the pointer, scanning upward with wrap from N_MASTER-1 to 0. Move to GRANT.
- Arbitration latency: exactly 1 cycle. A request seen at edge t is visible on gnt_o and s_cyc_o after edge t.
- State GRANT: s_* outputs are a combinational mux of the granted master's inputs.
  - s_cyc_o = granted m_cyc_i; s_stb_o = granted m_stb_i.
  - s_ack_i and s_err_i are routed only to the granted bit of m_ack_o/m_err_o. Non-granted masters see ack=0 and err=0.
  - m_dat_o = s_dat_i at all times.
- Release: when the granted master's m_cyc_i is low at an edge, clear gnt_o, set pointer = granted index + 1 (mod N_MASTER), and return to IDLE.
  - The next grant is issued no earlier than the following edge, which guarantees one idle cycle between owners.
- Non-granted requesters stall with no response. Their STB is ignored and never reaches the slave.
- CYC dropped in the same cycle as ACK is legal: the ACK is delivered and release happens at that edge.
- Simultaneous requests: the pointer alone decides the winner. No master waits more than N_MASTER-1 grants.
- s_ack_i or s_err_i asserted while no grant is held is ignored.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro defined: a counter clears on every s_ack_i, s_err_i or grant change, and increments each cycle while in GRANT with s_stb_o=1.
  - When the count reaches TIMEOUT, the arbiter pulses m_err_o of the granted master for 1 cycle, forces s_cyc_o/s_stb_o low for that cycle, and then releases exactly as on a normal CYC drop (pointer advances).
  - The counter width is $clog2(TIMEOUT+1).
- Without the macro: no counter exists, and a hung slave holds the grant indefinitely.

Decomposition:
- Shared package wb_pkg holds:
  - an arb_state_e enum (IDLE, GRANT);
  - default widths WB_ADDR_W=32 and WB_DATA_W=32.
- Sub-module rr_picker: combinational. Inputs are the request vector and the pointer; output is the one-hot winner. It is reusable by the crossbar.
- The top module holds the state register, the grant/pointer registers, the muxes and the optional watchdog.

Test Plan:
- Reset release, no requests -> gnt_o=0, s_cyc_o=0, all acks 0 for 20 cycles.
- Master 1 alone: CYC+STB write to adr 0x4010 with data 0xDEADBEEF -> gnt_o=3'b010 one cycle later; slave sees exactly that adr and data. s_ack_i is returned only on m_ack_o[1].
- Masters 0, 1 and 2 request together, each dropping CYC after 1 ack and then re-requesting -> grant order 0,1,2,0,1,2, with exactly 1 idle cycle between owners.
- Master 2 holds CYC across 4 read beats while master 0 requests -> master 0 gets no ack and s_adr_o never shows master 0's address until master 2 drops CYC.
- rstn_i pulled low during master 1's transaction -> gnt_o and s_cyc_o go to 0 asynchronously. After reset the pointer is 0 and master 0 wins a tie with master 1.
- WB_ARB_TIMEOUT_EN with TIMEOUT=8 and the slave never acking -> m_err_o[granted] pulses once, 8 cycles after STB rises. The grant is then released and the next requester is served.
